data_pack: RTL and testbench

//   Downstream stage of the data_convert block. Collects the byte stream it emits
//   on data_o/data_en into BYTES_PER_WORD-wide words. Completed or flushed words are

---
 rtl/data_pack_if.sv | 29 ++
 rtl/data_pack.sv | 104 ++++++++++
 tb/tb_data_pack.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_pack_if.sv
// Byte-in / word-out bus of the data_pack block.
// The master side feeds bytes and accepts words; the slave side is the packer.
interface data_pack_if #(
    parameter int BYTES_PER_WORD = 4,
    parameter int FIFO_DEPTH     = 4
);
    localparam int CW = $clog2(BYTES_PER_WORD) + 1;
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]                  data_in;
    logic                        data_en;
    logic                        flush;
    logic [8*BYTES_PER_WORD-1:0] word_o;
    logic [CW-1:0]               word_bytes;
    logic                        word_valid;
    logic                        word_ready;
    logic [LW-1:0]               fifo_level;
    logic                        overflow;

    modport master (
        output data_in, data_en, flush, word_ready,
        input  word_o, word_bytes, word_valid, fifo_level, overflow
    );

    modport slave (
        input  data_in, data_en, flush, word_ready,
        output word_o, word_bytes, word_valid, fifo_level, overflow
    );
endinterface

// File: rtl/data_pack.sv
// data_pack: collects a gappy byte stream into BYTES_PER_WORD-wide words,
// buffers finished or flushed words in a show-ahead FIFO and hands them
// downstream under valid/ready. Words lost to a full FIFO set a sticky flag.
module data_pack #(
    parameter int BYTES_PER_WORD = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter bit MSB_FIRST      = 1'b1
) (
    input logic       clk,
    input logic       reset,
    data_pack_if.slave bus
);
    localparam int CW = $clog2(BYTES_PER_WORD) + 1;
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int WW = 8 * BYTES_PER_WORD;

    logic [WW-1:0] asm_q;
    logic [WW-1:0] asm_ins;
    logic [WW-1:0] push_word;
    logic [CW-1:0] cnt;
    logic [CW-1:0] push_bytes;
    logic          last_byte;
    logic          push;
    logic          pop;
    logic          full;
    logic          accept;
    logic          drop;
    int            lane;

    logic [WW-1:0] mem_word  [FIFO_DEPTH];
    logic [CW-1:0] mem_bytes [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic          ovf_q;

    // Merge the incoming byte into its lane and decide whether a word leaves the assembler
    always_comb begin
        lane      = MSB_FIRST ? (BYTES_PER_WORD - 1 - int'(cnt)) : int'(cnt);
        asm_ins   = asm_q;
        asm_ins[lane*8 +: 8] = bus.data_in;
        last_byte = (cnt == CW'(BYTES_PER_WORD - 1));
        // A byte arriving together with flush is included before the flush acts
        push       = bus.data_en ? (last_byte || bus.flush) : (bus.flush && (cnt != '0));
        push_word  = bus.data_en ? asm_ins : asm_q;
        push_bytes = bus.data_en ? (cnt + CW'(1)) : cnt;
        // A same-edge pop frees the slot, so a full FIFO only drops when nothing leaves
        pop    = (level != '0) && bus.word_ready;
        full   = (level == LW'(FIFO_DEPTH));
        accept = push && (!full || pop);
        drop   = push && full && !pop;
    end

    // Assembly register and byte count; any push (kept or dropped) realigns the stream
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            asm_q <= '0;
            cnt   <= '0;
        end else if (push) begin
            asm_q <= '0;
            cnt   <= '0;
        end else if (bus.data_en) begin
            asm_q <= asm_ins;
            cnt   <= cnt + CW'(1);
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level + LW'(accept) - LW'(pop);
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // FIFO storage; contents are qualified by the pointers so they need no reset
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_word[wr_ptr]  <= push_word;
            mem_bytes[wr_ptr] <= push_bytes;
        end
    end

    // Show-ahead head; forced to zero while empty so stale storage never leaks out
    assign bus.word_valid = (level != '0);
    assign bus.word_o     = bus.word_valid ? mem_word[rd_ptr]  : '0;
    assign bus.word_bytes = bus.word_valid ? mem_bytes[rd_ptr] : '0;
    assign bus.fifo_level = level;
    assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_data_pack.sv
// Testbench for data_pack: an MSB-first and an LSB-first instance share the
// same stimulus; a scoreboard queue holds the words each should emit.
module tb_data_pack;
    localparam int B = 4;
    localparam int D = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    data_pack_if #(.BYTES_PER_WORD(B), .FIFO_DEPTH(D)) bus_m ();
    data_pack_if #(.BYTES_PER_WORD(B), .FIFO_DEPTH(D)) bus_l ();

    data_pack #(.BYTES_PER_WORD(B), .FIFO_DEPTH(D), .MSB_FIRST(1'b1)) dut_m (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_m.slave)
    );

    data_pack #(.BYTES_PER_WORD(B), .FIFO_DEPTH(D), .MSB_FIRST(1'b0)) dut_l (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_l.slave)
    );

    typedef struct {
        logic [31:0] wm;
        logic [31:0] wl;
        logic [2:0]  nb;
    } exp_t;

    exp_t       sb[$];
    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] m_bytes[B];
    int         m_cnt = 0;
    int         m_lvl = 0;
    logic       m_ovf = 1'b0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic drive(input logic en, input logic [7:0] d, input logic fl, input logic rdy);
        bus_m.data_en = en; bus_m.data_in = d; bus_m.flush = fl; bus_m.word_ready = rdy;
        bus_l.data_en = en; bus_l.data_in = d; bus_l.flush = fl; bus_l.word_ready = rdy;
    endtask

    task automatic model_clear();
        sb.delete();
        m_cnt = 0;
        m_lvl = 0;
        m_ovf = 1'b0;
    endtask

    task automatic zero_chk(input string tag);
        check({tag, "_word_m"},  64'(bus_m.word_o),     64'h0);
        check({tag, "_word_l"},  64'(bus_l.word_o),     64'h0);
        check({tag, "_bytes"},   64'(bus_m.word_bytes), 64'h0);
        check({tag, "_valid"},   64'(bus_m.word_valid), 64'h0);
        check({tag, "_level"},   64'(bus_m.fifo_level), 64'h0);
        check({tag, "_ovf"},     64'(bus_m.overflow),   64'h0);
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic cyc(input logic en, input logic [7:0] d, input logic fl, input logic rdy);
        exp_t e;
        logic push;
        logic pop;
        int   n;
        drive(en, d, fl, rdy);
        #1;
        check("valid_m", 64'(bus_m.word_valid), 64'(m_lvl > 0));
        check("valid_l", 64'(bus_l.word_valid), 64'(m_lvl > 0));
        check("level",   64'(bus_m.fifo_level), 64'(m_lvl));
        check("ovf",     64'(bus_m.overflow),   64'(m_ovf));
        if (m_lvl > 0 && sb.size() > 0) begin
            check("head_m",  64'(bus_m.word_o),     64'(sb[0].wm));
            check("head_l",  64'(bus_l.word_o),     64'(sb[0].wl));
            check("head_nb", 64'(bus_m.word_bytes), 64'(sb[0].nb));
        end
        pop = (m_lvl > 0) && rdy;
        if (pop && sb.size() > 0) void'(sb.pop_front());
        push = 1'b0;
        if (en) begin
            m_bytes[m_cnt] = d;
            m_cnt++;
            push = (m_cnt == B) || fl;
        end else begin
            push = fl && (m_cnt > 0);
        end
        if (push) begin
            n = m_cnt;
            e.wm = '0;
            e.wl = '0;
            for (int i = 0; i < n; i++) begin
                e.wm[(B-1-i)*8 +: 8] = m_bytes[i];
                e.wl[i*8 +: 8]       = m_bytes[i];
            end
            e.nb  = 3'(n);
            m_cnt = 0;
            if (m_lvl < D || pop) begin
                sb.push_back(e);
                m_lvl++;
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (pop) m_lvl--;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int ncyc);
        #2 reset = 1'b1;
        #1 zero_chk("rst_async");
        for (int i = 0; i < ncyc; i++) begin
            drive(i[0], 8'hEE, 1'b0, 1'b1);
            @(posedge clk);
            @(negedge clk);
            zero_chk("rst_hold");
        end
        reset = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        model_clear();
    endtask

    task automatic send_word(input logic [7:0] base, input logic rdy);
        for (int i = 0; i < B; i++) cyc(1'b1, base + 8'(i), 1'b0, rdy);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);

        // 1: reset with data_en toggling
        do_reset(4);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);

        // 2: back-to-back full word, both lane orders
        cyc(1'b1, 8'h84, 1'b0, 1'b1);
        cyc(1'b1, 8'h21, 1'b0, 1'b1);
        cyc(1'b1, 8'h69, 1'b0, 1'b1);
        cyc(1'b1, 8'hA5, 1'b0, 1'b1);
        check("t2_word_m", 64'(bus_m.word_o),     64'h842169A5);
        check("t2_word_l", 64'(bus_l.word_o),     64'hA5692184);
        check("t2_bytes",  64'(bus_m.word_bytes), 64'd4);
        check("t2_valid",  64'(bus_m.word_valid), 64'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check("t2_gone",   64'(bus_m.word_valid), 64'd0);

        // 3: gappy bytes then flush; second flush is a no-op
        cyc(1'b1, 8'h11, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b1, 8'h22, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("t3_word_m", 64'(bus_m.word_o),     64'h11220000);
        check("t3_word_l", 64'(bus_l.word_o),     64'h00002211);
        check("t3_bytes",  64'(bus_m.word_bytes), 64'd2);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("t3_reflush", 64'(bus_m.fifo_level), 64'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        // 4: flush together with the third byte
        cyc(1'b1, 8'h11, 1'b0, 1'b0);
        cyc(1'b1, 8'h22, 1'b0, 1'b0);
        cyc(1'b1, 8'h33, 1'b1, 1'b0);
        check("t4_word_m", 64'(bus_m.word_o),     64'h11223300);
        check("t4_word_l", 64'(bus_l.word_o),     64'h00332211);
        check("t4_bytes",  64'(bus_m.word_bytes), 64'd3);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);

        // 5: five words into a stalled FIFO, then drain
        for (int w = 0; w < 5; w++) send_word(8'(8'h10 * (w + 1)), 1'b0);
        check("t5_level", 64'(bus_m.fifo_level), 64'd4);
        check("t5_ovf",   64'(bus_m.overflow),   64'd1);
        for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check("t5_empty",   64'(bus_m.word_valid), 64'd0);
        check("t5_ovf_hold", 64'(bus_m.overflow),  64'd1);
        check("t5_sb",      64'(sb.size()),        64'd0);

        // 6: push and pop on the same edge while full, then mid-word reset
        do_reset(2);
        for (int w = 0; w < 4; w++) send_word(8'(8'h40 + 8'h08 * w), 1'b0);
        cyc(1'b1, 8'hB0, 1'b0, 1'b0);
        cyc(1'b1, 8'hB1, 1'b0, 1'b0);
        cyc(1'b1, 8'hB2, 1'b0, 1'b0);
        cyc(1'b1, 8'hB3, 1'b0, 1'b1);
        check("t6_level", 64'(bus_m.fifo_level), 64'd4);
        check("t6_ovf",   64'(bus_m.overflow),   64'd0);
        cyc(1'b1, 8'hD0, 1'b0, 1'b0);
        cyc(1'b1, 8'hD1, 1'b0, 1'b0);
        do_reset(2);
        cyc(1'b1, 8'hC1, 1'b0, 1'b1);
        cyc(1'b1, 8'hC2, 1'b0, 1'b1);
        cyc(1'b1, 8'hC3, 1'b0, 1'b1);
        cyc(1'b1, 8'hC4, 1'b0, 1'b1);
        check("t6_word_m", 64'(bus_m.word_o),     64'hC1C2C3C4);
        check("t6_word_l", 64'(bus_l.word_o),     64'hC4C3C2C1);
        check("t6_bytes",  64'(bus_m.word_bytes), 64'd4);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        // mixed random traffic against the scoreboard
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 7) == 0),
                1'($urandom_range(0, 2) == 0));
        end
        for (int i = 0; i < D + 1; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check("end_empty", 64'(bus_m.word_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
